// File: rtl/rd_channel_arbiter.sv
// ============================================================================
// Module   : rd_channel_arbiter
// Purpose  : Round-robin share of one AXI4 read master between two requesters;
//            an order FIFO routes returning R bursts. Optional counters under
//            RD_CHANNEL_ARBITER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_channel_arbiter #(
   parameter int C_ADDR_WIDTH      = 64,
   parameter int C_DATA_WIDTH      = 512,
   parameter int C_MAX_OUTSTANDING = 16
) (
   input  logic                    data_clk,
   input  logic                    data_rst_n,
   input  logic                    s0_arvalid,
   output logic                    s0_arready,
   input  logic [C_ADDR_WIDTH-1:0] s0_araddr,
   input  logic [7:0]              s0_arlen,
   output logic                    s0_rvalid,
   input  logic                    s0_rready,
   output logic [C_DATA_WIDTH-1:0] s0_rdata,
   output logic                    s0_rlast,
   input  logic                    s1_arvalid,
   output logic                    s1_arready,
   input  logic [C_ADDR_WIDTH-1:0] s1_araddr,
   input  logic [7:0]              s1_arlen,
   output logic                    s1_rvalid,
   input  logic                    s1_rready,
   output logic [C_DATA_WIDTH-1:0] s1_rdata,
   output logic                    s1_rlast,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic                    m_axi_rlast,
   output logic                    idle
`ifdef RD_CHANNEL_ARBITER_STATS_EN
   ,
   output logic [31:0]             stat_bursts0,
   output logic [31:0]             stat_bursts1,
   output logic [31:0]             stat_full_stall
`endif
);

   localparam int c_PTR_W = $clog2(C_MAX_OUTSTANDING);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(C_MAX_OUTSTANDING);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      r_last_grant;
   logic                      r_id;
   logic [C_ADDR_WIDTH-1:0]   r_addr;
   logic [7:0]                r_len;
   logic [C_MAX_OUTSTANDING-1:0] r_order_mem;
   logic [c_PTR_W-1:0]        r_wr_ptr;
   logic [c_PTR_W-1:0]        r_rd_ptr;
   logic [c_CNT_W-1:0]        r_count;

   logic w_grant;
   logic w_grant_id;
   logic w_push;
   logic w_pop;
   logic w_empty;
   logic w_full;
   logic w_head;
   logic w_req_any;

   assign w_req_any = s0_arvalid | s1_arvalid;
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == c_FULL_CNT);
   assign w_head    = r_order_mem[r_rd_ptr];

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_grant_id  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_any && !w_full) begin
               w_grant     = 1'b1;
               // Tie goes to the port that did not win last time.
               w_grant_id  = (s0_arvalid && s1_arvalid) ? ~r_last_grant : s1_arvalid;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (m_axi_arready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge data_clk or negedge data_rst_n) begin
      if (!data_rst_n) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_id         <= 1'b0;
         r_addr       <= '0;
         r_len        <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_last_grant <= w_grant_id;
            r_id         <= w_grant_id;
            r_addr       <= w_grant_id ? s1_araddr : s0_araddr;
            r_len        <= w_grant_id ? s1_arlen  : s0_arlen;
         end
      end
   end

   // Reset gating keeps the combinational grant pulse quiet while in reset.
   assign s0_arready    = data_rst_n & w_grant & ~w_grant_id;
   assign s1_arready    = data_rst_n & w_grant &  w_grant_id;
   assign m_axi_arvalid = (r_state == ST_ISSUE);
   assign m_axi_araddr  = r_addr;
   assign m_axi_arlen   = r_len;

   assign w_push = (r_state == ST_ISSUE) & m_axi_arready;
   assign w_pop  = m_axi_rvalid & m_axi_rready & m_axi_rlast;

   always_ff @(posedge data_clk) begin
      if (w_push) begin
         r_order_mem[r_wr_ptr] <= r_id;
      end
   end

   always_ff @(posedge data_clk or negedge data_rst_n) begin
      if (!data_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign s0_rvalid    = m_axi_rvalid & ~w_empty & ~w_head;
   assign s1_rvalid    = m_axi_rvalid & ~w_empty &  w_head;
   assign m_axi_rready = ~w_empty & (w_head ? s1_rready : s0_rready);
   assign s0_rdata     = m_axi_rdata;
   assign s1_rdata     = m_axi_rdata;
   assign s0_rlast     = m_axi_rlast;
   assign s1_rlast     = m_axi_rlast;

   assign idle = (r_state == ST_IDLE) & w_empty & ~w_req_any;

`ifdef RD_CHANNEL_ARBITER_STATS_EN
   logic [31:0] r_bursts0;
   logic [31:0] r_bursts1;
   logic [31:0] r_full_stall;

   always_ff @(posedge data_clk or negedge data_rst_n) begin
      if (!data_rst_n) begin
         r_bursts0    <= '0;
         r_bursts1    <= '0;
         r_full_stall <= '0;
      end else begin
         if (w_push && !r_id && (r_bursts0 != 32'hFFFF_FFFF)) begin
            r_bursts0 <= r_bursts0 + 32'd1;
         end
         if (w_push && r_id && (r_bursts1 != 32'hFFFF_FFFF)) begin
            r_bursts1 <= r_bursts1 + 32'd1;
         end
         if (w_req_any && w_full && (r_full_stall != 32'hFFFF_FFFF)) begin
            r_full_stall <= r_full_stall + 32'd1;
         end
      end
   end

   assign stat_bursts0    = r_bursts0;
   assign stat_bursts1    = r_bursts1;
   assign stat_full_stall = r_full_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rd_channel_arbiter.sv
// ============================================================================
// Module   : tb_rd_channel_arbiter
// Purpose  : Self-checking bench for rd_channel_arbiter (vector table plus
//            hand-written multi-cycle sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rd_channel_arbiter;

   localparam int AW = 64;
   localparam int DW = 512;

   logic          data_clk = 1'b0;
   logic          data_rst_n;
   logic          s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
   logic          s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
   logic [AW-1:0] s0_araddr, s1_araddr, m_axi_araddr;
   logic [7:0]    s0_arlen, s1_arlen, m_axi_arlen;
   logic [DW-1:0] s0_rdata, s1_rdata, m_axi_rdata;
   logic          m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
   logic          idle;
`ifdef RD_CHANNEL_ARBITER_STATS_EN
   logic [31:0]   stat_bursts0, stat_bursts1, stat_full_stall;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 data_clk = ~data_clk;

   rd_channel_arbiter #(
      .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(16)
   ) dut (
      .data_clk(data_clk), .data_rst_n(data_rst_n),
      .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
      .s0_arlen(s0_arlen), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
      .s0_rdata(s0_rdata), .s0_rlast(s0_rlast),
      .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
      .s1_arlen(s1_arlen), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
      .s1_rdata(s1_rdata), .s1_rlast(s1_rlast),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
      .idle(idle)
`ifdef RD_CHANNEL_ARBITER_STATS_EN
      ,
      .stat_bursts0(stat_bursts0), .stat_bursts1(stat_bursts1),
      .stat_full_stall(stat_full_stall)
`endif
   );

   // in  = {s0_arvalid, s1_arvalid, m_arready, m_rvalid, m_rlast, s0_rready, s1_rready}
   // exp = {s0_arready, s1_arready, m_arvalid, m_rready, s0_rvalid, s1_rvalid, idle}
   typedef struct {
      logic [6:0]  in;
      logic [6:0]  exp;
      logic [63:0] addr;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] in);
      {s0_arvalid, s1_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast, s0_rready, s1_rready} = in;
   endtask

   task automatic do_reset();
      data_rst_n = 1'b0;
      drive(7'b0);
      repeat (2) @(negedge data_clk);
      data_rst_n = 1'b1;
   endtask

   initial begin
      int grants;
      int model_cnt;
      int gid[$];
`ifdef RD_CHANNEL_ARBITER_STATS_EN
      int stall_model;
`endif
      s0_araddr   = 64'h1000;
      s0_arlen    = 8'd3;
      s1_araddr   = 64'h2000;
      s1_arlen    = 8'd1;
      m_axi_rdata = {8{64'hA5A5_0000_1234_5678}};

      vecs.push_back('{7'b0000000, 7'b0000001, 64'h0});    // reset state
      vecs.push_back('{7'b1010000, 7'b1000000, 64'h0});    // grant port 0
      vecs.push_back('{7'b0010000, 7'b0010000, 64'h1000}); // ISSUE, handshake
      vecs.push_back('{7'b0001010, 7'b0001100, 64'h0});    // beat to port 0
      vecs.push_back('{7'b0001000, 7'b0000100, 64'h0});    // s0_rready low
      vecs.push_back('{7'b0001111, 7'b0001100, 64'h0});    // rlast pop
      vecs.push_back('{7'b0000000, 7'b0000001, 64'h0});    // idle again
      vecs.push_back('{7'b0001111, 7'b0000001, 64'h0});    // R while empty
      vecs.push_back('{7'b1100000, 7'b0100000, 64'h0});    // tie -> port 1
      vecs.push_back('{7'b1100000, 7'b0010000, 64'h2000}); // arready low
      vecs.push_back('{7'b1110000, 7'b0010000, 64'h2000}); // handshake id 1
      vecs.push_back('{7'b1110000, 7'b1000000, 64'h0});    // tie -> port 0
      vecs.push_back('{7'b0010000, 7'b0010000, 64'h1000}); // handshake id 0
      vecs.push_back('{7'b0001110, 7'b0000010, 64'h0});    // head 1, s1_rready low
      vecs.push_back('{7'b0001101, 7'b0001010, 64'h0});    // port 1 pop
      vecs.push_back('{7'b0001110, 7'b0001100, 64'h0});    // port 0 pop
      vecs.push_back('{7'b0000000, 7'b0000001, 64'h0});    // drained

      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge data_clk);
         drive(vecs[i].in);
         #1;
         chk($sformatf("v%0d_s0_arready", i), 64'(s0_arready), 64'(vecs[i].exp[6]));
         chk($sformatf("v%0d_s1_arready", i), 64'(s1_arready), 64'(vecs[i].exp[5]));
         chk($sformatf("v%0d_m_arvalid", i), 64'(m_axi_arvalid), 64'(vecs[i].exp[4]));
         chk($sformatf("v%0d_m_rready", i), 64'(m_axi_rready), 64'(vecs[i].exp[3]));
         chk($sformatf("v%0d_s0_rvalid", i), 64'(s0_rvalid), 64'(vecs[i].exp[2]));
         chk($sformatf("v%0d_s1_rvalid", i), 64'(s1_rvalid), 64'(vecs[i].exp[1]));
         chk($sformatf("v%0d_idle", i), 64'(idle), 64'(vecs[i].exp[0]));
         if (vecs[i].exp[4]) begin
            chk($sformatf("v%0d_araddr", i), m_axi_araddr, vecs[i].addr);
         end
      end
      chk("rdata_fanout0", s0_rdata[63:0], 64'hA5A5_0000_1234_5678);
      chk("rdata_fanout1", s1_rdata[63:0], 64'hA5A5_0000_1234_5678);

      // arready held low for 5 cycles in ISSUE
      do_reset();
      @(negedge data_clk);
      drive(7'b1000000);
      #1 chk("stall_grant", 64'(s0_arready), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge data_clk);
         #1;
         chk($sformatf("stall%0d_arvalid", i), 64'(m_axi_arvalid), 64'd1);
         chk($sformatf("stall%0d_addr", i), m_axi_araddr, 64'h1000);
         chk($sformatf("stall%0d_len", i), 64'(m_axi_arlen), 64'd3);
         chk($sformatf("stall%0d_no_arready", i), 64'(s0_arready), 64'd0);
      end
      @(negedge data_clk);
      drive(7'b0010000);
      #1 chk("stall_hs_arvalid", 64'(m_axi_arvalid), 64'd1);
      @(negedge data_clk);
      drive(7'b0000000);
      #1 chk("stall_one_pending", 64'(idle), 64'd0);
      @(negedge data_clk);
      drive(7'b0001110);
      #1 chk("stall_rvalid0", 64'(s0_rvalid), 64'd1);
      @(negedge data_clk);
      drive(7'b0000000);
      #1 chk("stall_single_push", 64'(idle), 64'd1);

      // Fill the order FIFO, check blocking and the pop-then-grant timing
      do_reset();
      grants = 0;
      model_cnt = 0;
`ifdef RD_CHANNEL_ARBITER_STATS_EN
      stall_model = 0;
`endif
      for (int i = 0; i < 40; i++) begin
         @(negedge data_clk);
         drive(7'b1010000);
         #1;
         if (s0_arready) grants++;
`ifdef RD_CHANNEL_ARBITER_STATS_EN
         if (model_cnt == 16) stall_model++;
`endif
         if (m_axi_arvalid && m_axi_arready) model_cnt++;
      end
      chk("full_grants", 64'(grants), 64'd16);
      @(negedge data_clk);
      #1 chk("full_blocked", 64'(s0_arready), 64'd0);
`ifdef RD_CHANNEL_ARBITER_STATS_EN
      chk("stat_full_stall", 64'(stat_full_stall), 64'(stall_model));
      chk("stat_bursts0", 64'(stat_bursts0), 64'd16);
      chk("stat_bursts1", 64'(stat_bursts1), 64'd0);
      stall_model++;
`endif
      @(negedge data_clk);
      drive(7'b1011110);
      #1;
      chk("full_pop_same_cycle", 64'(s0_arready), 64'd0);
      chk("full_pop_rready", 64'(m_axi_rready), 64'd1);
`ifdef RD_CHANNEL_ARBITER_STATS_EN
      stall_model++;
`endif
      @(negedge data_clk);
      drive(7'b1010000);
      #1 chk("full_grant_after_pop", 64'(s0_arready), 64'd1);
`ifdef RD_CHANNEL_ARBITER_STATS_EN
      chk("stat_full_stall_end", 64'(stat_full_stall), 64'(stall_model));
`endif

      // Alternating grants, then reset with 4 bursts outstanding
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge data_clk);
         drive(7'b1110000);
         #1;
         if (s0_arready) gid.push_back(0);
         if (s1_arready) gid.push_back(1);
      end
      chk("alt_count", 64'(gid.size()), 64'd4);
      for (int i = 0; i < gid.size() && i < 4; i++) begin
         chk($sformatf("alt_id%0d", i), 64'(gid[i]), 64'(i % 2));
      end
      @(negedge data_clk);
      drive(7'b0001011);
      #1;
      chk("alt_head0_s0", 64'(s0_rvalid), 64'd1);
      chk("alt_head0_s1", 64'(s1_rvalid), 64'd0);
      #2 data_rst_n = 1'b0;
      #1;
      chk("rst_s0_rvalid", 64'(s0_rvalid), 64'd0);
      chk("rst_m_rready", 64'(m_axi_rready), 64'd0);
      chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("rst_araddr", m_axi_araddr, 64'h0);
      chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
      chk("rst_idle", 64'(idle), 64'd1);
      @(negedge data_clk);
      data_rst_n = 1'b1;
      @(negedge data_clk);
      #1;
      chk("post_rst_idle", 64'(idle), 64'd1);
      chk("post_rst_rready", 64'(m_axi_rready), 64'd0);
      chk("post_rst_s0_rvalid", 64'(s0_rvalid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
